// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared constants for the data-port bridge: MMIO window base, register word offsets,
// STATUS bit layout, and a byte-lane merge helper for byte-enabled register writes.
package dmem_mmio_bridge_pkg;

  localparam logic [7:0] MMIO_BASE_DEF = 8'hFF;

  // Word offsets (cpu_addr[7:2]); byte offsets are these values times 4
  localparam logic [5:0] OFF_TXDATA  = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h01;
  localparam logic [5:0] OFF_CYCLE   = 6'h02;
  localparam logic [5:0] OFF_CMP     = 6'h03;
  localparam logic [5:0] OFF_CTRL    = 6'h04;
  localparam logic [5:0] OFF_DROPCNT = 6'h05;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_COUNT = 8;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_TX_EN  = 1;

  function automatic logic [31:0] byte_merge(logic [31:0] old, logic [31:0] wdata,
                                             logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dmem_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full succeeds only alongside a pop.
module dmem_mmio_bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so the output is defined straight out of reset
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;

endmodule

// File: rtl/dmem_mmio_bridge.sv
// CPU data-port bridge: routes accesses to SRAM or an MMIO window (TX FIFO, cycle counter,
// compare/irq, drop counter) while keeping the 1-cycle read latency of the SRAM path.
module dmem_mmio_bridge
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int         TX_DEPTH  = 8,
  parameter logic [7:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] cpu_addr,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_datain,
  output logic [31:0] cpu_dataout,
  output logic [15:0] sram_addr,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_datain,
  input  logic [31:0] sram_dataout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          mmio_sel, is_wr;
  logic [5:0]    off;
  logic          push, pop, drop, full, empty;
  logic [CW-1:0] count;
  logic [7:0]    count8;
  logic [31:0]   cycle, cmp, rdata, mmio_rdata_q;
  logic [1:0]    ctrl;
  logic [15:0]   dropcnt;
  logic          sel_q;
  logic          unused_addr;

  assign mmio_sel    = (cpu_addr[15:8] == MMIO_BASE);
  assign off         = cpu_addr[7:2];
  assign is_wr       = |cpu_wen;
  assign unused_addr = ^cpu_addr[1:0];

  assign sram_addr   = cpu_addr;
  assign sram_datain = cpu_datain;
  assign sram_wen    = mmio_sel ? 4'b0000 : cpu_wen;

  assign push     = mmio_sel & (off == OFF_TXDATA) & cpu_wen[0];
  assign pop      = tx_valid & tx_ready;
  assign drop     = push & full & ~pop;
  assign tx_valid = ~empty & ctrl[CTRL_TX_EN];
  assign count8   = 8'(count);

  assign timer_irq = ctrl[CTRL_IRQ_EN] & (cycle >= cmp);

  dmem_mmio_bridge_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .din   (cpu_datain[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_STATUS: begin
        rdata[ST_EMPTY]     = empty;
        rdata[ST_FULL]      = full;
        rdata[ST_COUNT +: 8] = count8;
      end
      OFF_CYCLE:   rdata = cycle;
      OFF_CMP:     rdata = cmp;
      OFF_CTRL:    rdata[1:0] = ctrl;
      OFF_DROPCNT: rdata[15:0] = dropcnt;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cycle        <= '0;
      cmp          <= 32'hFFFF_FFFF;
      ctrl         <= '0;
      dropcnt      <= '0;
      sel_q        <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      sel_q        <= mmio_sel;
      mmio_rdata_q <= rdata;
      // A CPU write to CYCLE takes priority over the free-running increment
      if (mmio_sel && is_wr && off == OFF_CYCLE)
        cycle <= byte_merge(cycle, cpu_datain, cpu_wen);
      else
        cycle <= cycle + 32'd1;
      if (mmio_sel && is_wr && off == OFF_CMP)
        cmp <= byte_merge(cmp, cpu_datain, cpu_wen);
      if (mmio_sel && cpu_wen[0] && off == OFF_CTRL)
        ctrl <= cpu_datain[1:0];
      if (mmio_sel && is_wr && off == OFF_DROPCNT)
        dropcnt <= '0;
      else if (drop && dropcnt != 16'hFFFF)
        dropcnt <= dropcnt + 16'd1;
    end
  end

  assign cpu_dataout = sel_q ? mmio_rdata_q : sram_dataout;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: SRAM passthrough, MMIO registers, TX FIFO, timer, reset.
module tb_dmem_mmio_bridge;
  logic        clk, nrst;
  logic [15:0] cpu_addr;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_datain, cpu_dataout;
  logic [15:0] sram_addr;
  logic [3:0]  sram_wen;
  logic [31:0] sram_datain, sram_dataout;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, timer_irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] v;
  logic [31:0] smem [256];

  localparam logic [15:0] IDLE = 16'h0100;

  dmem_mmio_bridge #(.TX_DEPTH(8), .MMIO_BASE(8'hFF)) dut (
    .clk(clk), .nrst(nrst), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
    .cpu_datain(cpu_datain), .cpu_dataout(cpu_dataout), .sram_addr(sram_addr),
    .sram_wen(sram_wen), .sram_datain(sram_datain), .sram_dataout(sram_dataout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with 1-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (sram_wen[i]) smem[sram_addr[9:2]][8*i +: 8] <= sram_datain[8*i +: 8];
    sram_dataout <= smem[sram_addr[9:2]];
  end

  task automatic cyc(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
    cpu_addr = a; cpu_wen = w; cpu_datain = d;
    @(posedge clk); #1;
    cpu_addr = IDLE; cpu_wen = 4'h0; cpu_datain = 32'h0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] val);
    cyc(a, 4'h0, 32'h0);
    val = cpu_dataout;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", timer_irq); end
    @(posedge clk); #1; nrst = 1'b1;
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL rst_status got=%h exp=00000001", v); end
    rd(16'hFF0C, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp got=%h exp=ffffffff", v); end
    rd(16'hFF10, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", v); end
    rd(16'hFF14, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_dropcnt got=%h exp=0", v); end
  endtask

  task automatic test_sram;
    cpu_addr = 16'h0010; cpu_wen = 4'hF; cpu_datain = 32'hDEAD_BEEF; #1;
    checks++; if (sram_wen !== 4'hF) begin failures++; $display("FAIL sram_wen got=%h exp=f", sram_wen); end
    @(posedge clk); #1; cpu_wen = 4'h0;
    rd(16'h0010, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sram_read got=%h exp=deadbeef", v); end
  endtask

  task automatic test_mmio_isolation;
    cpu_addr = 16'hFF0C; cpu_wen = 4'hF; cpu_datain = 32'h0000_0100; #1;
    checks++; if (sram_wen !== 4'h0) begin failures++; $display("FAIL mmio_sram_wen got=%h exp=0", sram_wen); end
    checks++; if (sram_addr !== 16'hFF0C) begin failures++; $display("FAIL sram_addr got=%h exp=ff0c", sram_addr); end
    @(posedge clk); #1; cpu_wen = 4'h0;
    rd(16'hFF0C, v);
    checks++; if (v !== 32'h0000_0100) begin failures++; $display("FAIL cmp_read got=%h exp=00000100", v); end
    cyc(16'hFF0C, 4'b0001, 32'hAAAA_AA55);
    rd(16'hFF0C, v);
    checks++; if (v !== 32'h0000_0155) begin failures++; $display("FAIL cmp_byte_en got=%h exp=00000155", v); end
    cyc(16'hFF40, 4'hF, 32'h1234_5678);
    rd(16'hFF40, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", v); end
  endtask

  task automatic test_cycle;
    cyc(16'hFF08, 4'hF, 32'd100);
    rd(16'hFF08, v);
    checks++; if (v !== 32'd100) begin failures++; $display("FAIL cycle_rd0 got=%0d exp=100", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 32'd101) begin failures++; $display("FAIL cycle_rd1 got=%0d exp=101", v); end
  endtask

  task automatic test_fifo_fill_drop;
    tx_ready = 1'b0;
    cyc(16'hFF10, 4'hF, 32'h2);
    for (int i = 0; i < 10; i++) cyc(16'hFF00, 4'h1, i);
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0802) begin failures++; $display("FAIL fill_status got=%h exp=00000802", v); end
    rd(16'hFF14, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL fill_dropcnt got=%0d exp=2", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'(i)}) begin
        failures++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(i));
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_done got=%b exp=0", tx_valid); end
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL drain_status got=%h exp=00000001", v); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_b;
    for (int i = 0; i < 8; i++) cyc(16'hFF00, 4'h1, 32'h10 + i);
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0802) begin failures++; $display("FAIL pp_full got=%h exp=00000802", v); end
    tx_ready = 1'b1;
    cyc(16'hFF00, 4'h1, 32'hA5);
    tx_ready = 1'b0;
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0802) begin failures++; $display("FAIL pp_status got=%h exp=00000802", v); end
    rd(16'hFF14, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL pp_dropcnt got=%0d exp=2", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'hA5 : 8'(8'h11 + i);
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, exp_b}) begin
        failures++; $display("FAIL pp_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    cyc(16'hFF14, 4'h1, 32'h0);
    rd(16'hFF14, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL drop_clear got=%0d exp=0", v); end
  endtask

  task automatic test_timer;
    cyc(16'hFF0C, 4'hF, 32'd20);
    cyc(16'hFF10, 4'hF, 32'h3);
    cyc(16'hFF08, 4'hF, 32'd15);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_at15 got=%b exp=0", timer_irq); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_early[%0d] got=%b exp=0", k, timer_irq); end
    end
    @(posedge clk); #1;
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", timer_irq); end
    cyc(16'hFF08, 4'hF, 32'd0);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", timer_irq); end
  endtask

  task automatic test_reset_mid;
    cyc(16'hFF0C, 4'hF, 32'd0);
    cyc(16'hFF00, 4'h1, 32'h31);
    cyc(16'hFF00, 4'h1, 32'h32);
    cyc(16'hFF10, 4'hF, 32'h1);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL txen_clear got=%b exp=0", tx_valid); end
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0200) begin failures++; $display("FAIL txen_retain got=%h exp=00000200", v); end
    cyc(16'hFF10, 4'hF, 32'h3);
    checks++;
    if ({tx_valid, tx_data, timer_irq} !== {1'b1, 8'h31, 1'b1}) begin
      failures++; $display("FAIL pre_rst got=%b/%h/%b exp=1/31/1", tx_valid, tx_data, timer_irq);
    end
    tx_ready = 1'b1;
    #3 nrst = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_data, timer_irq} !== {1'b0, 8'h00, 1'b0}) begin
      failures++; $display("FAIL mid_rst got=%b/%h/%b exp=0/00/0", tx_valid, tx_data, timer_irq);
    end
    tx_ready = 1'b0;
    @(posedge clk); #1; nrst = 1'b1;
    rd(16'hFF08, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL rst_cycle got=%0d exp=0", v); end
    rd(16'hFF0C, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst2_cmp got=%h exp=ffffffff", v); end
    rd(16'hFF10, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst2_ctrl got=%h exp=0", v); end
    rd(16'hFF04, v);
    checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL rst2_status got=%h exp=00000001", v); end
  endtask

  initial begin
    nrst = 1'b0; tx_ready = 1'b0;
    cpu_addr = IDLE; cpu_wen = 4'h0; cpu_datain = 32'h0;
    test_reset();
    test_sram();
    test_mmio_isolation();
    test_cycle();
    test_fifo_fill_drop();
    test_full_push_pop();
    test_timer();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
